// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter with start/busy/done handshake
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BIN_WIDTH-1:0] bin_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [3:0]           ones_o,
  output logic [3:0]           tens_o,
  output logic [3:0]           hundreds_o,
  output logic [3:0]           thousands_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [15:0]          scratch_q, scratch_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [15:0]          digits_q, digits_d;
  logic                 overflow_q, overflow_d;

  logic [15:0]          adj;
  logic [BIN_WIDTH+15:0] shifted;

  // Add-3 correction per nibble; a nibble <= 9 becomes <= 12, so no carry crosses nibbles.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;
  end

  // Next-state logic: load on accepted start, shift one bit per cycle, publish digits on the last shift.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d      = bin_i;
          scratch_d  = 16'd0;
          cnt_d      = 5'(BIN_WIDTH);
          ovf_pend_d = (32'(bin_i) > 32'd9999);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[BIN_WIDTH+15:BIN_WIDTH];
        bin_d     = shifted[BIN_WIDTH-1:0];
        cnt_d     = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          // Digits update atomically so they are valid during the DONE cycle.
          digits_d   = ovf_pend_q ? 16'h9999 : shifted[BIN_WIDTH+15:BIN_WIDTH];
          overflow_d = ovf_pend_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= 16'd0;
      cnt_q      <= 5'd0;
      ovf_pend_q <= 1'b0;
      digits_q   <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = overflow_q;
  assign thousands_o = digits_q[15:12];
  assign hundreds_o  = digits_q[11:8];
  assign tens_o      = digits_q[7:4];
  assign ones_o      = digits_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  localparam int BW = 14;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [BW-1:0] bin_i;
  logic          start_i;
  logic          busy_o, done_o, overflow_o;
  logic [3:0]    ones_o, tens_o, hundreds_o, thousands_o;

  bin_to_bcd_seq #(.BIN_WIDTH(BW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bin_i       (bin_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .ones_o      (ones_o),
    .tens_o      (tens_o),
    .hundreds_o  (hundreds_o),
    .thousands_o (thousands_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    int          dcyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   done_cnt = 0;
  int   nib_bad  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tot_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("digits", {16'd0, thousands_o, hundreds_o, tens_o, ones_o}, {16'd0, e.dig});
        chk("overflow", {31'd0, overflow_o}, {31'd0, e.ovf});
        chk("done_cycle", cyc, e.dcyc);
        chk("busy_in_done", {31'd0, busy_o}, 32'd1);
      end
    end
  end

  // Nibble range observer during SHIFT.
  always @(negedge clk_i) begin
    if (busy_o === 1'b1 && done_o === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (dut.scratch_q[4*i +: 4] > 4'd9) nib_bad++;
      end
    end
  end

  task automatic push(input logic [15:0] dig, input logic ovf, input int dcyc);
    exp_t e;
    e.dig  = dig;
    e.ovf  = ovf;
    e.dcyc = dcyc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    step();
  endtask

  task automatic conv(input int v, input logic [15:0] dig, input logic ovf);
    bin_i   = BW'(v);
    start_i = 1'b1;
    push(dig, ovf, cyc + BW + 1);
    step();
    start_i = 1'b0;
    drain();
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    int c;
    int dc;
    rst_i   = 1'b1;
    start_i = 1'b0;
    bin_i   = '0;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_ovf", {31'd0, overflow_o}, 32'd0);
    chk("reset_digits", {16'd0, thousands_o, hundreds_o, tens_o, ones_o}, 32'd0);
    step();

    // Test 1: 1234 with busy profile over cycles 1..16.
    c       = cyc;
    bin_i   = BW'(1234);
    start_i = 1'b1;
    push(16'h1234, 1'b0, c + 15);
    for (int k = 1; k <= 16; k++) begin
      step();
      start_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("busy_c%0d", k), {31'd0, busy_o}, (k <= 15) ? 32'd1 : 32'd0);
    end
    drain();
    repeat (3) step();
    chk("hold_digits", {16'd0, thousands_o, hundreds_o, tens_o, ones_o}, 32'h1234);

    // Test 2 and 3: boundaries and saturation.
    conv(0, 16'h0000, 1'b0);
    conv(9999, 16'h9999, 1'b0);
    conv(10000, 16'h9999, 1'b1);
    conv(42, 16'h0042, 1'b0);
    conv(16383, 16'h9999, 1'b1);

    // Test 4: start held while busy, bin changed mid-conversion.
    c       = cyc;
    bin_i   = BW'(5678);
    start_i = 1'b1;
    push(16'h5678, 1'b0, c + 15);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 5) bin_i = BW'(1111);
      if (k == 16) push(16'h1111, 1'b0, c + 31);
    end
    step();
    start_i = 1'b0;
    drain();

    // Test 5: reset mid-conversion aborts with no done pulse.
    dc      = done_cnt;
    bin_i   = BW'(4321);
    start_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      start_i = 1'b0;
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_digits", {16'd0, thousands_o, hundreds_o, tens_o, ones_o}, 32'd0);
    chk("abort_ovf", {31'd0, overflow_o}, 32'd0);
    repeat (20) step();
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    conv(4321, 16'h4321, 1'b0);

    // Test 6: sparse sweep against a reference model.
    for (int v = 0; v <= 9999; v += 7) conv(v, ref_bcd(v), 1'b0);
    conv(9999, ref_bcd(9999), 1'b0);

    chk("nibble_le9", 32'(nib_bad), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, tot_cnt);
    $fatal(1, "watchdog");
  end

endmodule
